// File: rtl/axi_cmd_master.sv
// axi_cmd_master: converts single-beat commands into AXI4 read/write transactions.
// One transaction is outstanding at a time. Each response is held until rsp_ready.
// Optional feature: define AXI_CMD_MASTER_TIMEOUT_EN to enable the response timeout.
module axi_cmd_master #(
  parameter int unsigned TAGW    = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            rst_l,
  // command side
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [31:0]     cmd_addr,
  input  logic [63:0]     cmd_wdata,
  input  logic [7:0]      cmd_wstrb,
  // response side
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [63:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_timeout,
  // AXI4 read address
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [TAGW-1:0] arid,
  output logic [7:0]      arlen,
  output logic [1:0]      arburst,
  output logic [2:0]      arsize,
  // AXI4 read data
  input  logic            rvalid,
  output logic            rready,
  input  logic [63:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic [TAGW-1:0] rid,
  input  logic            rlast,
  // AXI4 write address
  output logic            awvalid,
  input  logic            awready,
  output logic [31:0]     awaddr,
  output logic [TAGW-1:0] awid,
  output logic [7:0]      awlen,
  output logic [1:0]      awburst,
  output logic [2:0]      awsize,
  // AXI4 write data
  output logic            wvalid,
  input  logic            wready,
  output logic [63:0]     wdata,
  output logic [7:0]      wstrb,
  output logic            wlast,
  // AXI4 write response
  input  logic            bvalid,
  output logic            bready,
  input  logic [1:0]      bresp,
  input  logic [TAGW-1:0] bid
);

  typedef enum logic [2:0] {StIdle, StRdA, StRdD, StWrAw, StWrB, StRsp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        aw_ok, w_ok;
  logic        tmo_hit;

  // Single-beat, 8-byte INCR bursts with ID zero.
  assign arid    = '0;
  assign awid    = '0;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arsize  = 3'b011;
  assign awsize  = 3'b011;
  assign wlast   = 1'b1;

  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;

  // Handshake outputs are pure state decodes so reset clears them immediately.
  // cmd_ready is also gated by rst_l so it is low while reset is held.
  assign cmd_ready = (state_q == StIdle) & rst_l;
  assign arvalid   = (state_q == StRdA);
  assign rready    = (state_q == StRdD);
  assign awvalid   = (state_q == StWrAw) & ~aw_done_q;
  assign wvalid    = (state_q == StWrAw) & ~w_done_q;
  assign bready    = (state_q == StWrB);
  assign rsp_valid = (state_q == StRsp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and latched-field computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    aw_ok       = 1'b0;
    w_ok        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrAw : StRdA;
        end
      end
      StRdA: begin
        if (arready) state_d = StRdD;
      end
      StRdD: begin
        if (rvalid) begin
          rsp_rdata_d = rdata;
          rsp_err_d   = (rresp != 2'b00) | (rid != '0) | ~rlast;
          state_d     = StRsp;
        end else if (tmo_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StRsp;
        end
      end
      StWrAw: begin
        // Each channel completes independently; leave once both have.
        aw_ok     = aw_done_q | awready;
        w_ok      = w_done_q | wready;
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) state_d = StWrB;
      end
      StWrB: begin
        if (bvalid) begin
          rsp_rdata_d = '0;
          rsp_err_d   = (bresp != 2'b00) | (bid != '0);
          state_d     = StRsp;
        end else if (tmo_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-field registers.
  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            rsp_tmo_q, rsp_tmo_d;
  logic            wait_st;
  logic            slave_rsp;

  assign wait_st   = (state_q == StRdD) | (state_q == StWrB);
  assign slave_rsp = (state_q == StRdD) ? rvalid : bvalid;
  // Fires on the TIMEOUT-th waiting cycle, so RSP starts TIMEOUT cycles after entry.
  assign tmo_hit   = wait_st & ~slave_rsp & (tmo_cnt_q == CntW'(TIMEOUT - 1));
  assign rsp_timeout = rsp_tmo_q;

  // Wait counter: counts while waiting, clears whenever the state changes.
  always_comb begin
    tmo_cnt_d = '0;
    rsp_tmo_d = rsp_tmo_q;
    if (wait_st && (state_d == state_q)) tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (wait_st) rsp_tmo_d = tmo_hit;
  end

  // Timeout counter and flag registers.
  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      tmo_cnt_q <= '0;
      rsp_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_tmo_q <= rsp_tmo_d;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/axi_cmd_master.md
AXI_CMD_MASTER -- requirements
Module: axi_cmd_master

Interface
REQ-001 Parameters: TAGW, default 1, AXI ID width; TIMEOUT, default 1024, response timeout in aclk cycles.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, with ports listed below as name, direction, width, meaning.
REQ-003 aclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_l  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_write, cmd_addr, cmd_wdata, cmd_wstrb  input  1/32/64/8  write flag, byte address, write data, byte strobes.
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  response consumed.
REQ-010 rsp_rdata, rsp_err, rsp_timeout  output  64/1/1  read data, nonzero resp or ID mismatch, timeout flag.
REQ-011 arvalid, awvalid, wvalid, rready, bready  output  1 each  AXI4 handshakes.
REQ-012 arready, awready, wready, rvalid, bvalid, rlast  input  1 each  AXI4 handshakes and last beat.
REQ-013 araddr, awaddr  output  32  equal to the latched cmd_addr.
REQ-014 arid, awid  output  TAGW  all zeros; rid, bid  input  TAGW.
REQ-015 arlen, awlen = 0 (8b); arburst, awburst = 2'b01 (2b); arsize, awsize = 3'b011 (3b); wlast = 1: all are constant outputs.
REQ-016 wdata, wstrb  output  64/8  latched command data; rdata  input  64; rresp, bresp  input  2.

Function
REQ-017 FSM states SHALL be IDLE, RD_A, RD_D, WR_AW, WR_B, RSP, with one transaction outstanding at most.
REQ-018 cmd_ready SHALL be 1 only in IDLE; on acceptance, the block latches cmd_* and moves to RD_A if cmd_write=0, else WR_AW.
REQ-019 RD_A: arvalid=1 until arready is sampled high, then RD_D; araddr and the latched fields stay stable while arvalid=1.
REQ-020 RD_D: rready=1; on rvalid, latch rdata and set rsp_err = (rresp!=0)|(rid!=0)|(rlast==0), then go to RSP.
REQ-021 WR_AW: awvalid and wvalid are asserted together and each drops independently on its own ready; go to WR_B in the cycle both handshakes are complete, including the same-cycle case.
REQ-022 WR_B: bready=1; on bvalid, set rsp_err = (bresp!=0)|(bid!=0) and rsp_rdata=0, then go to RSP.
REQ-023 RSP: rsp_valid=1 and outputs are held until rsp_ready, then IDLE; a cmd_valid present in that cycle is not accepted until the next cycle.
REQ-024 Minimum latency with zero-wait slave: accept cycle 0, AR/AW handshake cycle 1, R/B cycle 2, rsp_valid cycle 3.
REQ-025 Unexpected rvalid or bvalid outside RD_D or WR_B SHALL be ignored, with rready and bready held at 0.

Reset
REQ-026 On rst_l=0, state=IDLE and every valid/ready output, rsp_rdata, rsp_err and rsp_timeout SHALL go to 0 asynchronously.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no response; first command acceptance is possible in the first cycle after rst_l rises.

Configuration
REQ-028 With AXI_CMD_MASTER_TIMEOUT_EN defined, a counter runs in RD_D and WR_B; reaching TIMEOUT cycles forces RSP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, and the counter clears on state exit; without it, the block waits indefinitely and rsp_timeout is tied 0.

Verification
REQ-029 Write 0x1122334455667788, wstrb 0xFF, to 0x00001000, then read it back from a memory responder -> rsp_rdata=0x1122334455667788, rsp_err=0.
REQ-030 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 4, exactly one B accepted.
REQ-031 Read with rresp=2'b10 -> rsp_err=1; read with rid=1 (TAGW=1) -> rsp_err=1.
REQ-032 rsp_ready held low 5 cycles while cmd_valid=1 -> outputs stable, cmd_ready=0 until the cycle after rsp_ready.
REQ-033 rst_l pulsed low while in RD_D -> all valids 0 immediately, no rsp_valid, next read completes normally.
REQ-034 AXI_CMD_MASTER_TIMEOUT_EN with TIMEOUT=16 and no rvalid -> rsp_valid with rsp_err=1, rsp_timeout=1, 16 cycles after entering RD_D.
